// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state encoding, the number of bytes per
// instruction, and the address and instruction typedefs.
package fetch_pkg;

  // The FSM alternates between fetching the even (high) byte and the
  // odd (low) byte of each 16-bit instruction.
  typedef enum logic {
    FETCH_HI = 1'b0,
    FETCH_LO = 1'b1
  } fetch_state_t;

  localparam int INSTR_BYTES = 2;

  typedef logic [7:0]  addr_t;
  typedef logic [15:0] instr_t;

endpackage

// File: rtl/fetch_pc.sv
// fetch_pc
// Program counter register for the fetch stage.
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset, PC returns to 0
//   advance   - step PC to the next byte, wrapping after PROG_LAST
//   load      - redirect PC to load_addr (has priority over advance)
//   load_addr - redirect target; bit 0 is cleared so the PC lands even
//   pc        - current PC, straight from the flop
module fetch_pc #(
  parameter int ADDR_W    = 8,
  parameter int PROG_LAST = 45
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LAST);

  // Any PC at or past the end of the image (reachable through a jump
  // beyond the image) wraps back to the start instead of running on.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr & ~ADDR_W'(1);
    end else if (advance) begin
      if (pc >= LAST_ADDR) begin
        pc <= '0;
      end else begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage feeding decode. Reads the byte-wide program
// memory one byte per cycle, pairs an even-address byte with the
// following odd-address byte into a 16-bit instruction and offers it
// over a valid/ready handshake. Supports jump redirection with flush.
// Ports:
//   Clock      - system clock, rising edge
//   Reset      - synchronous active-high reset
//   Address    - program memory byte address (the PC flop itself)
//   Data       - byte read from program memory at Address, same cycle
//   Instr      - assembled instruction {even byte, odd byte}
//   InstrValid - Instr holds an instruction decode has not yet taken
//   Ready      - decode takes Instr at this edge when InstrValid is set
//   Jump       - single-cycle redirect request
//   JumpTarget - redirect byte address, bit 0 ignored
// Optional feature: define FETCH_TRACE_EN to print a simulation trace
// line on every instruction load and every jump.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int PROG_LAST = 45,
  parameter int INSTR_W   = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  Address,
  input  logic [7:0]         Data,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  input  logic               Ready,
  input  logic               Jump,
  input  logic [ADDR_W-1:0]  JumpTarget
);

  localparam int BYTE_W = INSTR_W / INSTR_BYTES;

  fetch_state_t      state;
  logic [BYTE_W-1:0] hi_byte;
  logic              lo_can_load;
  logic              pc_advance;

  // The low-byte fetch may only complete when the output register is
  // free or is being emptied at this same edge; otherwise it stalls.
  assign lo_can_load = !InstrValid || Ready;
  assign pc_advance  = (state == FETCH_HI) || lo_can_load;

  fetch_pc #(
    .ADDR_W    (ADDR_W),
    .PROG_LAST (PROG_LAST)
  ) u_pc (
    .clk       (Clock),
    .reset     (Reset),
    .advance   (pc_advance),
    .load      (Jump),
    .load_addr (JumpTarget),
    .pc        (Address)
  );

  // Fetch FSM and output register. A jump flushes the partial high byte
  // and any pending instruction, but leaves Instr's value untouched.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= FETCH_HI;
      hi_byte    <= '0;
      Instr      <= '0;
      InstrValid <= 1'b0;
    end else if (Jump) begin
      state      <= FETCH_HI;
      InstrValid <= 1'b0;
    end else begin
      case (state)
        FETCH_HI: begin
          hi_byte <= Data;
          state   <= FETCH_LO;
          if (InstrValid && Ready) begin
            InstrValid <= 1'b0;
          end
        end
        FETCH_LO: begin
          if (lo_can_load) begin
            Instr      <= {hi_byte, Data};
            InstrValid <= 1'b1;
            state      <= FETCH_HI;
          end
        end
        default: state <= FETCH_HI;
      endcase
    end
  end

`ifdef FETCH_TRACE_EN
  // Simulation-only trace; mirrors the load and jump conditions above.
  always @(posedge Clock) begin
    if (!Reset) begin
      if (Jump) begin
        $display("%t fetch JUMP target=%h", $time, JumpTarget);
      end else if (state == FETCH_LO && lo_can_load) begin
        $display("%t fetch PC=%h INSTR=%h", $time, Address, {hi_byte, Data});
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit: a table of per-edge vectors covering
// reset, streaming, backpressure, jumps and reset while holding, plus
// hand-written sequences for image wrap and jumps past the image end.
module tb_fetch_unit;

  logic        Clock;
  logic        Reset;
  logic [7:0]  Address;
  logic [7:0]  Data;
  logic [15:0] Instr;
  logic        InstrValid;
  logic        Ready;
  logic        Jump;
  logic [7:0]  JumpTarget;

  logic [7:0] mem [0:255];

  int check_count = 0;
  int error_count = 0;

  typedef struct {
    logic        reset;
    logic        ready;
    logic        jump;
    logic [7:0]  target;
    logic [7:0]  exp_addr;
    logic [15:0] exp_instr;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [24];

  fetch_unit dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Address    (Address),
    .Data       (Data),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .Ready      (Ready),
    .Jump       (Jump),
    .JumpTarget (JumpTarget)
  );

  // Program memory model: combinational read
  assign Data = mem[Address];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [7:0] exp_addr,
                             input logic [15:0] exp_instr, input logic exp_valid);
    check_count++;
    if (Address !== exp_addr) begin
      error_count++;
      $display("[TB] FAIL %s Address: got %h want %h", name, Address, exp_addr);
    end
    check_count++;
    if (Instr !== exp_instr) begin
      error_count++;
      $display("[TB] FAIL %s Instr: got %h want %h", name, Instr, exp_instr);
    end
    check_count++;
    if (InstrValid !== exp_valid) begin
      error_count++;
      $display("[TB] FAIL %s InstrValid: got %b want %b", name, InstrValid, exp_valid);
    end
  endtask

  // Drive inputs, take one rising edge, then sample just after it
  task automatic applyStimulus(input logic rst, input logic rdy,
                               input logic jmp, input logic [7:0] tgt);
    Reset      = rst;
    Ready      = rdy;
    Jump       = jmp;
    JumpTarget = tgt;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int cycles;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0]  = 8'h12;
    mem[1]  = 8'h34;
    mem[2]  = 8'h56;
    mem[3]  = 8'h78;
    mem[44] = 8'hAB;
    mem[45] = 8'hCD;

    // reset, ready, jump, target, exp Address, exp Instr, exp InstrValid
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 16'h1234, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 16'h1234, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 16'h1234, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 16'h1234, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 16'h5678, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 16'h5678, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h06, 16'h0405, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 16'h0405, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h0B, 8'h0A, 16'h0405, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h0B, 16'h0405, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h0C, 16'h0A0B, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h0D, 16'h0A0B, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h0E, 16'h0C0D, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h14, 8'h14, 16'h0C0D, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h15, 16'h0C0D, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h16, 16'h1415, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h17, 16'h1415, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 16'h0000, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 16'h0000, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 16'h1234, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 16'h1234, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 16'h5678, 1'b1};

    Reset = 1'b1; Ready = 1'b0; Jump = 1'b0; JumpTarget = 8'h00;
    #2;

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].reset, vecs[i].ready, vecs[i].jump, vecs[i].target);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_instr,
                  vecs[i].exp_valid);
    end

    // Wrap: stream with Ready=1 until the PC reaches 44 (an even, high-byte slot)
    cycles = 0;
    while (Address != 8'd44 && cycles < 200) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      cycles++;
    end
    check_count++;
    if (Address != 8'd44) begin
      error_count++;
      $display("[TB] FAIL wrap_reach: Address got %h want 2c", Address);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    check_count++;
    if (Address !== 8'd45) begin
      error_count++;
      $display("[TB] FAIL wrap_lo Address: got %h want 2d", Address);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_abcd", 8'h00, 16'hABCD, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_hi", 8'h01, 16'hABCD, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_1234", 8'h02, 16'h1234, 1'b1);

    // Jump past the image end: next(PC) from 0x30 must wrap to 0
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h31);
    checkOutput("far_jump", 8'h30, 16'h1234, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("far_hi", 8'h00, 16'h1234, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("far_lo", 8'h01, 16'h3012, 1'b1);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the byte-wide program memory.
- Drives the memory address and samples its combinationally-read byte. Assembles two consecutive bytes into one 16-bit instruction and presents it to the decode stage over a valid/ready handshake.
- Handles sequential PC advance with wrap at the end of the program image, and jump redirection with flush.

Parameters:
ADDR_W, 8, width of the program address / PC
PROG_LAST, 45, last valid byte address of the program image; PC wraps to 0 after it
INSTR_W, 16, assembled instruction width (fixed 2 x 8 bits)

Ports:
Clock  input  1  single system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Address  output  ADDR_W  byte address to program memory; equals PC register directly (no logic after the flop)
Data  input  8  byte returned by program memory for current Address, valid in the same cycle
Instr  output  INSTR_W  assembled instruction, {high byte at even address, low byte at odd address}
InstrValid  output  1  Instr holds an unconsumed instruction
Ready  input  1  decode stage accepts Instr at this edge when InstrValid=1
Jump  input  1  redirect request, single-cycle pulse
JumpTarget  input  ADDR_W  byte target of jump; bit 0 ignored (forced even)

Behaviour:
- Reset (Reset=1 at edge, highest priority): PC=0, state=FETCH_HI, hi-byte reg=0, Instr=0, InstrValid=0.
- Transfer: occurs at an edge where InstrValid=1 and Ready=1.
- FETCH_HI:
  - hi-byte reg <= Data.
  - PC <= next(PC).
  - state <= FETCH_LO.
  - Never stalls.
- FETCH_LO:
  - If InstrValid=0 or Ready=1:
    - Instr <= {hi-byte reg, Data}.
    - InstrValid <= 1.
    - PC <= next(PC).
    - state <= FETCH_HI.
  - Otherwise (output full, not consumed): hold PC, state, Instr and InstrValid. Address stays stable.
- InstrValid clears at an edge with transfer and no new load.
- Back-to-back: load and transfer in the same edge leave InstrValid=1 with the new Instr.
- next(PC): PC==PROG_LAST or PC>PROG_LAST gives 0; otherwise PC+1. Arithmetic is ADDR_W bits unsigned, no overflow past 2^ADDR_W.
- Jump=1 (priority over normal fetch, below Reset):
  - PC <= {JumpTarget[ADDR_W-1:1],1'b0}.
  - state <= FETCH_HI.
  - Partial hi byte discarded.
  - InstrValid <= 0, Instr unchanged.
  - A simultaneous transfer (InstrValid=1, Ready=1) counts as consumed. A non-consumed valid instruction is dropped.
- Latency:
  - First InstrValid=1 two edges after Reset deasserts.
  - First instruction after a jump two edges after the Jump edge.
  - Peak throughput: one instruction per 2 cycles.
- Ready while InstrValid=0 has no effect.
- Jump while Reset=1 is ignored.

Optional Feature:
- Macro: FETCH_TRACE_EN.
- Defined: simulation-only $display at every Instr load, format "%t fetch PC=%h INSTR=%h", plus a display on every Jump with target.
- Undefined: no display code compiled.
- Cycle behaviour identical in both cases.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {FETCH_HI, FETCH_LO}
  - localparam INSTR_BYTES=2
  - typedef addr_t logic[7:0]
  - typedef instr_t logic[15:0]
- One sub-module, fetch_pc:
  - PC register with synchronous reset, hold, increment-with-wrap (PROG_LAST parameter) and even-aligned load.
  - fetch_unit instantiates it and owns the FSM and output register.

Test Plan:
- Image mem[0]=12, mem[1]=34, mem[2]=56, mem[3]=78, Ready=1, Reset released -> Address 0,1,2,3; Instr=1234 valid after edge 2, 5678 after edge 4, InstrValid stays 1.
- Backpressure: Ready=0 after first instruction -> at edge 4 Address holds 3, Instr holds 1234, InstrValid=1. Ready=1 one cycle -> Instr=5678 next edge, Address=4.
- Wrap: run to PC=44 with mem[44]=AB, mem[45]=CD -> Instr=ABCD, Address returns to 0, next Instr=1234.
- Jump=1, JumpTarget=0B (odd) while in FETCH_LO with InstrValid=1, Ready=0 -> InstrValid=0 next edge, Address=0A, Instr={mem[10],mem[11]} valid two edges later.
- Jump coincident with transfer (InstrValid=1, Ready=1) -> old Instr counted consumed once, no new load that edge, InstrValid=0.
- Reset asserted mid-FETCH_LO with InstrValid=1 -> next edge Address=0, InstrValid=0, Instr=0, state FETCH_HI. Normal 1234 sequence after release.
